// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one byte-wide RAM port between the instruction
// fetch unit (4-byte reads) and the load/store buffer (1/2/4-byte accesses).
module mem_port_arbiter #(
   parameter int unsigned IO_SEL_HI = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rob_rollback_in,
   input  logic        if_request_in,
   input  logic [31:0] if_address_in,
   output logic        if_ready_out,
   output logic [31:0] if_data_out,
   input  logic        lsb_request_in,
   input  logic        lsb_rw_signal_in,
   input  logic [31:0] lsb_address_in,
   input  logic [2:0]  lsb_goal_in,
   input  logic [31:0] lsb_data_in,
   output logic        lsb_ready_out,
   output logic [31:0] lsb_data_out,
   output logic [31:0] ram_address_out,
   output logic [7:0]  ram_data_out,
   output logic        ram_rw_signal_out,
   input  logic [7:0]  ram_data_in,
   input  logic        io_buffer_full_in
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  len_q, len_d;
   logic [31:0] base_q, base_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        lsb_own_q, lsb_own_d;
   logic        if_ready_q, if_ready_d;
   logic        lsb_ready_q, lsb_ready_d;
   logic [31:0] if_data_q, if_data_d;
   logic [31:0] lsb_data_q, lsb_data_d;
   logic        pend_q, pend_d;
   logic        pend_rw_q, pend_rw_d;
   logic [31:0] pend_addr_q, pend_addr_d;
   logic [31:0] pend_data_q, pend_data_d;
   logic [2:0]  pend_len_q, pend_len_d;

   logic        take_pend;
   logic [31:0] addr_cur;
   logic        io_stall;
   logic        cool;
   logic [1:0]  rd_lane;

   // Illegal byte counts fall back to a full word.
   function automatic logic [2:0] goal_len(input logic [2:0] goal);
      return (goal == 3'd1 || goal == 3'd2) ? goal : 3'd4;
   endfunction

   assign addr_cur = base_q + {29'd0, cnt_q};
   assign io_stall = (addr_cur[IO_SEL_HI -: 2] == 2'b11) && io_buffer_full_in;
   // A ready pulse marks the mandatory idle cycle after a completion.
   assign cool     = if_ready_q | lsb_ready_q;
   // The byte arriving now was addressed one cycle earlier.
   assign rd_lane  = cnt_q[1:0] - 2'd1;

   // Pending LSB slot: latch when empty, drop loads on rollback, free when taken.
   always_comb begin
      pend_d      = pend_q;
      pend_rw_d   = pend_rw_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      pend_len_d  = pend_len_q;
      if (take_pend) pend_d = 1'b0;
      if (rob_rollback_in && !pend_rw_q) pend_d = 1'b0;
      if (lsb_request_in && !pend_q && (lsb_rw_signal_in || !rob_rollback_in)) begin
         pend_d      = 1'b1;
         pend_rw_d   = lsb_rw_signal_in;
         pend_addr_d = lsb_address_in;
         pend_data_d = lsb_data_in;
         pend_len_d  = goal_len(lsb_goal_in);
      end
   end

   // Transaction FSM: request selection, byte sequencing and completion.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      lsb_own_d   = lsb_own_q;
      if_ready_d  = 1'b0;
      lsb_ready_d = 1'b0;
      if_data_d   = if_data_q;
      lsb_data_d  = lsb_data_q;
      take_pend   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!cool) begin
               if (pend_q && (pend_rw_q || !rob_rollback_in)) begin
                  take_pend = 1'b1;
                  base_d    = pend_addr_q;
                  len_d     = pend_len_q;
                  wdata_d   = pend_data_q;
                  lsb_own_d = 1'b1;
                  cnt_d     = 3'd0;
                  rdata_d   = '0;
                  state_d   = pend_rw_q ? StWrite : StRead;
               end else if (if_request_in && !rob_rollback_in) begin
                  base_d    = if_address_in;
                  len_d     = 3'd4;
                  lsb_own_d = 1'b0;
                  cnt_d     = 3'd0;
                  rdata_d   = '0;
                  state_d   = StRead;
               end
            end
         end
         StRead: begin
            if (rob_rollback_in) begin
               state_d = StIdle;
               cnt_d   = 3'd0;
            end else begin
               if (cnt_q != 3'd0) rdata_d[{rd_lane, 3'b000} +: 8] = ram_data_in;
               if (cnt_q == len_q) begin
                  state_d = StIdle;
                  cnt_d   = 3'd0;
                  if (lsb_own_q) begin
                     lsb_ready_d = 1'b1;
                     lsb_data_d  = rdata_d;
                  end else begin
                     if_ready_d = 1'b1;
                     if_data_d  = rdata_d;
                  end
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         StWrite: begin
            if (!io_stall) begin
               if (cnt_q == len_q - 3'd1) begin
                  state_d     = StIdle;
                  cnt_d       = 3'd0;
                  lsb_ready_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // RAM port drive: quiet in idle, write strobe withheld while the I/O sink is full.
   always_comb begin
      ram_address_out   = '0;
      ram_data_out      = '0;
      ram_rw_signal_out = 1'b0;
      unique case (state_q)
         StRead: ram_address_out = addr_cur;
         StWrite: begin
            ram_address_out   = addr_cur;
            ram_data_out      = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            ram_rw_signal_out = !io_stall;
         end
         default: ;
      endcase
   end

   assign if_ready_out  = if_ready_q;
   assign if_data_out   = if_data_q;
   assign lsb_ready_out = lsb_ready_q;
   assign lsb_data_out  = lsb_data_q;

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         len_q       <= '0;
         base_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         lsb_own_q   <= 1'b0;
         if_ready_q  <= 1'b0;
         lsb_ready_q <= 1'b0;
         if_data_q   <= '0;
         lsb_data_q  <= '0;
         pend_q      <= 1'b0;
         pend_rw_q   <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         pend_len_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         lsb_own_q   <= lsb_own_d;
         if_ready_q  <= if_ready_d;
         lsb_ready_q <= lsb_ready_d;
         if_data_q   <= if_data_d;
         lsb_data_q  <= lsb_data_d;
         pend_q      <= pend_d;
         pend_rw_q   <= pend_rw_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         pend_len_q  <= pend_len_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: randomized transactions checked
// against a transaction-level model (byte memory, latency formulas).
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rob_rollback_in, if_request_in, lsb_request_in, lsb_rw_signal_in;
   logic        io_buffer_full_in;
   logic [31:0] if_address_in, lsb_address_in, lsb_data_in;
   logic [2:0]  lsb_goal_in;
   logic [7:0]  ram_data_in;
   logic        if_ready_out, lsb_ready_out, ram_rw_signal_out;
   logic [31:0] if_data_out, lsb_data_out, ram_address_out;
   logic [7:0]  ram_data_out;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int both_cnt = 0;

   typedef struct {int c; logic [31:0] a; logic [31:0] d;} ev_t;
   ev_t if_q[$], lsb_q[$], wr_q[$];
   logic [31:0] atr [int];
   logic [7:0]  mem_ovr [logic [31:0]];

   mem_port_arbiter #(.IO_SEL_HI(17)) dut (
      .clk(clk), .rst(rst), .rob_rollback_in(rob_rollback_in),
      .if_request_in(if_request_in), .if_address_in(if_address_in),
      .if_ready_out(if_ready_out), .if_data_out(if_data_out),
      .lsb_request_in(lsb_request_in), .lsb_rw_signal_in(lsb_rw_signal_in),
      .lsb_address_in(lsb_address_in), .lsb_goal_in(lsb_goal_in),
      .lsb_data_in(lsb_data_in), .lsb_ready_out(lsb_ready_out),
      .lsb_data_out(lsb_data_out), .ram_address_out(ram_address_out),
      .ram_data_out(ram_data_out), .ram_rw_signal_out(ram_rw_signal_out),
      .ram_data_in(ram_data_in), .io_buffer_full_in(io_buffer_full_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference memory contents: fixed overrides, else a hash of the address.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      if (mem_ovr.exists(a)) return mem_ovr[a];
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
   endfunction

   function automatic int exp_len(input logic [2:0] g);
      return (g == 3'd1 || g == 3'd2) ? int'(g) : 4;
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
      logic [31:0] r;
      logic [31:0] ai;
      r = '0;
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         r[8*i +: 8] = mem_byte(ai);
      end
      return r;
   endfunction

   // RAM: read data appears one cycle after its address.
   always @(posedge clk) ram_data_in <= mem_byte(ram_address_out);

   // Event monitor, sampled mid-cycle.
   always @(negedge clk) begin
      atr[cyc] = ram_address_out;
      if (if_ready_out) if_q.push_back('{c: cyc, a: 32'd0, d: if_data_out});
      if (lsb_ready_out) lsb_q.push_back('{c: cyc, a: 32'd0, d: lsb_data_out});
      if (ram_rw_signal_out) wr_q.push_back('{c: cyc, a: ram_address_out, d: {24'd0, ram_data_out}});
      if (if_ready_out && lsb_ready_out) both_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      if_q.delete();
      lsb_q.delete();
      wr_q.delete();
   endtask

   task automatic run_if(input logic [31:0] a, output int t);
      step();
      if_request_in = 1'b1;
      if_address_in = a;
      t = cyc;
      for (int k = 0; k < 14; k++) begin
         step();
         if (if_ready_out) if_request_in = 1'b0;
      end
      if_request_in = 1'b0;
   endtask

   task automatic run_lsb(input logic rw, input logic [31:0] a, input logic [2:0] g,
                          input logic [31:0] d, output int t);
      step();
      lsb_request_in   = 1'b1;
      lsb_rw_signal_in = rw;
      lsb_address_in   = a;
      lsb_goal_in      = g;
      lsb_data_in      = d;
      t = cyc + 1;
      step();
      lsb_request_in = 1'b0;
      repeat (12) step();
   endtask

   task automatic test_reset();
      int t;
      logic [31:0] ea;
      rst = 1'b0;
      {rob_rollback_in, if_request_in, lsb_request_in, lsb_rw_signal_in} = '0;
      io_buffer_full_in = 1'b0;
      {if_address_in, lsb_address_in, lsb_data_in} = '0;
      lsb_goal_in = '0;
      repeat (3) step();
      n_cmp++;
      if ({if_ready_out, if_data_out, lsb_ready_out, lsb_data_out, ram_address_out,
           ram_data_out, ram_rw_signal_out} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: addr=%h rw=%b ifr=%b lsbr=%b, required all zero",
                  ram_address_out, ram_rw_signal_out, if_ready_out, lsb_ready_out);
      end
      // Release and request in the same cycle: sampled at the first edge after release.
      step();
      rst = 1'b1;
      if_request_in = 1'b1;
      if_address_in = 32'h0000_2468;
      t = cyc;
      clr();
      for (int k = 0; k < 12; k++) begin
         step();
         if (if_ready_out) if_request_in = 1'b0;
      end
      if_request_in = 1'b0;
      ea = 32'h2468;
      n_cmp++;
      if (atr[t+1] !== ea) begin
         n_fail++;
         $display("FAIL first_after_release: addr %h, required %h", atr[t+1], ea);
      end
      n_cmp++;
      if (if_q.size() != 1 || if_q[0].c != t + 6) begin
         n_fail++;
         $display("FAIL release_read_ready: %0d pulses, required 1 at cycle %0d", if_q.size(), t + 6);
      end
   endtask

   task automatic test_if_read();
      int t;
      logic [31:0] a, ea, ed;
      mem_ovr[32'h1000] = 8'h13;
      mem_ovr[32'h1001] = 8'h05;
      mem_ovr[32'h1002] = 8'h00;
      mem_ovr[32'h1003] = 8'h00;
      mem_ovr[32'h0020] = 8'hF0;
      for (int k = 0; k < 7; k++) begin
         a = (k == 0) ? 32'h1000 : (k == 1) ? 32'hFFFF_FFFE : $urandom;
         ed = (k == 0) ? 32'h0000_0513 : exp_read(a, 4);
         clr();
         run_if(a, t);
         n_cmp++;
         if (if_q.size() != 1 || if_q[0].c != t + 6 || if_q[0].d !== ed) begin
            n_fail++;
            $display("FAIL if_read[%0d]: %0d pulses, data %h, required 1 at cycle %0d data %h",
                     k, if_q.size(), (if_q.size() > 0) ? if_q[0].d : 32'hx, t + 6, ed);
         end
         for (int i = 0; i < 4; i++) begin
            ea = a + 32'(i);
            n_cmp++;
            if (atr[t+1+i] !== ea) begin
               n_fail++;
               $display("FAIL if_addr[%0d][%0d]: %h, required %h", k, i, atr[t+1+i], ea);
            end
         end
         n_cmp++;
         if (lsb_q.size() != 0 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL if_side_effects: lsb %0d writes %0d, required 0/0", lsb_q.size(), wr_q.size());
         end
      end
   endtask

   task automatic test_lsb_load();
      int t, n;
      logic [31:0] a, ea, ed;
      logic [2:0] g;
      for (int k = 0; k < 8; k++) begin
         a = $urandom;
         g = (k < 3) ? 3'(k + 1) : 3'($urandom_range(0, 7));
         n = exp_len(g);
         ed = exp_read(a, n);
         clr();
         run_lsb(1'b0, a, g, $urandom, t);
         n_cmp++;
         if (lsb_q.size() != 1 || lsb_q[0].c != t + n + 2 || lsb_q[0].d !== ed) begin
            n_fail++;
            $display("FAIL load[%0d] goal %0d: %0d pulses, data %h, required 1 at %0d data %h",
                     k, g, lsb_q.size(), (lsb_q.size() > 0) ? lsb_q[0].d : 32'hx, t + n + 2, ed);
         end
         for (int i = 0; i < n; i++) begin
            ea = a + 32'(i);
            n_cmp++;
            if (atr[t+1+i] !== ea) begin
               n_fail++;
               $display("FAIL load_addr[%0d][%0d]: %h, required %h", k, i, atr[t+1+i], ea);
            end
         end
      end
   endtask

   task automatic test_lsb_store();
      int t, n;
      logic [31:0] a, d, ea;
      logic [2:0] g;
      for (int k = 0; k < 7; k++) begin
         if (k == 0) begin
            a = 32'h40; g = 3'd2; d = 32'h0000_BEEF;
         end else begin
            a = $urandom; g = 3'($urandom_range(0, 7)); d = $urandom;
         end
         n = exp_len(g);
         clr();
         run_lsb(1'b1, a, g, d, t);
         n_cmp++;
         if (wr_q.size() != n) begin
            n_fail++;
            $display("FAIL store_count[%0d]: %0d writes, required %0d", k, wr_q.size(), n);
         end
         for (int i = 0; i < n && i < wr_q.size(); i++) begin
            ea = a + 32'(i);
            n_cmp++;
            if (wr_q[i].c != t + 1 + i || wr_q[i].a !== ea || wr_q[i].d[7:0] !== d[8*i +: 8]) begin
               n_fail++;
               $display("FAIL store_byte[%0d][%0d]: cyc %0d %h=%h, required cyc %0d %h=%h", k, i,
                        wr_q[i].c, wr_q[i].a, wr_q[i].d[7:0], t + 1 + i, ea, d[8*i +: 8]);
            end
         end
         n_cmp++;
         if (lsb_q.size() != 1 || lsb_q[0].c != t + n + 1) begin
            n_fail++;
            $display("FAIL store_ready[%0d]: %0d pulses, required 1 at %0d", k, lsb_q.size(), t + n + 1);
         end
      end
   endtask

   task automatic test_pending_during_if();
      int t;
      clr();
      step();
      if_request_in = 1'b1;
      if_address_in = 32'h1000;
      t = cyc;
      step();
      step();
      lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b0; lsb_address_in = 32'h20; lsb_goal_in = 3'd1;
      step();
      lsb_request_in = 1'b0;
      for (int k = 0; k < 14; k++) begin
         step();
         if (if_ready_out) if_request_in = 1'b0;
      end
      if_request_in = 1'b0;
      n_cmp++;
      if (if_q.size() != 1 || if_q[0].c != t + 6 || if_q[0].d !== 32'h513) begin
         n_fail++;
         $display("FAIL pend_if_ready: %0d pulses, required 1 at %0d data 00000513", if_q.size(), t + 6);
      end
      n_cmp++;
      if (lsb_q.size() != 1 || lsb_q[0].c != t + 10 || lsb_q[0].d !== 32'hF0) begin
         n_fail++;
         $display("FAIL pend_lsb_ready: %0d pulses data %h, required 1 at %0d data 000000f0",
                  lsb_q.size(), (lsb_q.size() > 0) ? lsb_q[0].d : 32'hx, t + 10);
      end
      n_cmp++;
      if (atr[t+8] !== 32'h20) begin
         n_fail++;
         $display("FAIL pend_lsb_addr: %h, required 00000020", atr[t+8]);
      end
   endtask

   task automatic test_io_stall();
      int t;
      io_buffer_full_in = 1'b1;
      clr();
      run_lsb(1'b1, 32'h0002_0000, 3'd1, 32'h11, t);
      n_cmp++;
      if (wr_q.size() != 1 || wr_q[0].c != t + 1) begin
         n_fail++;
         $display("FAIL non_io_no_stall: %0d writes, required 1 at %0d", wr_q.size(), t + 1);
      end
      clr();
      step();
      lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b1; lsb_address_in = 32'h0003_0000;
      lsb_goal_in = 3'd1; lsb_data_in = 32'hA7;
      t = cyc + 1;
      step();
      lsb_request_in = 1'b0;
      repeat (5) step();
      step();
      io_buffer_full_in = 1'b0;
      repeat (6) step();
      n_cmp++;
      if (wr_q.size() != 1 || wr_q[0].c != t + 6 || wr_q[0].a !== 32'h30000 || wr_q[0].d !== 32'hA7) begin
         n_fail++;
         $display("FAIL io_stall_write: %0d writes, first cyc %0d, required 1 at %0d 00030000=a7",
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[0].c : -1, t + 6);
      end
      n_cmp++;
      if (lsb_q.size() != 1 || lsb_q[0].c != t + 7) begin
         n_fail++;
         $display("FAIL io_stall_ready: %0d pulses, required 1 at %0d", lsb_q.size(), t + 7);
      end
   endtask

   task automatic test_rollback();
      int t, nz;
      // Abort IF read at byte 2 with a store pending.
      clr();
      step();
      if_request_in = 1'b1; if_address_in = 32'h3000; t = cyc;
      step();
      lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b1; lsb_address_in = 32'h500;
      lsb_goal_in = 3'd1; lsb_data_in = 32'h5A;
      step();
      lsb_request_in = 1'b0;
      step();
      rob_rollback_in = 1'b1;
      step();
      rob_rollback_in = 1'b0; if_request_in = 1'b0;
      repeat (10) step();
      n_cmp++;
      if (if_q.size() != 0) begin
         n_fail++;
         $display("FAIL rb_if_no_ready: %0d pulses, required 0", if_q.size());
      end
      n_cmp++;
      if (wr_q.size() != 1 || wr_q[0].c != t + 5 || wr_q[0].a !== 32'h500 || wr_q[0].d !== 32'h5A) begin
         n_fail++;
         $display("FAIL rb_store_write: %0d writes, required 1 at %0d 00000500=5a", wr_q.size(), t + 5);
      end
      n_cmp++;
      if (lsb_q.size() != 1 || lsb_q[0].c != t + 6) begin
         n_fail++;
         $display("FAIL rb_store_ready: %0d pulses, required 1 at %0d", lsb_q.size(), t + 6);
      end
      // Abort an in-flight load.
      clr();
      step();
      lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b0; lsb_address_in = 32'h700; lsb_goal_in = 3'd4;
      t = cyc + 1;
      step();
      lsb_request_in = 1'b0;
      step();
      step();
      rob_rollback_in = 1'b1;
      step();
      rob_rollback_in = 1'b0;
      repeat (10) step();
      n_cmp++;
      if (lsb_q.size() != 0 || atr[t+3] !== 32'h0) begin
         n_fail++;
         $display("FAIL rb_load_abort: %0d pulses addr %h, required 0 pulses addr 0", lsb_q.size(), atr[t+3]);
      end
      // Pending load behind an IF read is discarded.
      clr();
      step();
      if_request_in = 1'b1; if_address_in = 32'h3000; t = cyc;
      step();
      lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b0; lsb_address_in = 32'h20; lsb_goal_in = 3'd1;
      step();
      lsb_request_in = 1'b0;
      step();
      rob_rollback_in = 1'b1;
      step();
      rob_rollback_in = 1'b0; if_request_in = 1'b0;
      repeat (10) step();
      nz = 0;
      for (int c = t + 4; c < t + 13; c++) if (atr[c] !== 32'h0) nz++;
      n_cmp++;
      if (if_q.size() != 0 || lsb_q.size() != 0 || nz != 0) begin
         n_fail++;
         $display("FAIL rb_pending_load: if %0d lsb %0d busy %0d, required 0/0/0", if_q.size(), lsb_q.size(), nz);
      end
      // Load pulse coincident with rollback is dropped.
      clr();
      step();
      rob_rollback_in = 1'b1;
      lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b0; lsb_address_in = 32'h20; lsb_goal_in = 3'd1;
      step();
      rob_rollback_in = 1'b0; lsb_request_in = 1'b0;
      repeat (8) step();
      n_cmp++;
      if (lsb_q.size() != 0) begin
         n_fail++;
         $display("FAIL rb_coincident_load: %0d pulses, required 0", lsb_q.size());
      end
      // Store pulse coincident with rollback is kept.
      clr();
      step();
      rob_rollback_in = 1'b1;
      lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b1; lsb_address_in = 32'h600;
      lsb_goal_in = 3'd1; lsb_data_in = 32'h3C;
      t = cyc;
      step();
      rob_rollback_in = 1'b0; lsb_request_in = 1'b0;
      repeat (8) step();
      n_cmp++;
      if (wr_q.size() != 1 || wr_q[0].c != t + 2 || lsb_q.size() != 1 || lsb_q[0].c != t + 3) begin
         n_fail++;
         $display("FAIL rb_coincident_store: writes %0d pulses %0d, required write at %0d ready at %0d",
                  wr_q.size(), lsb_q.size(), t + 2, t + 3);
      end
   endtask

   task automatic test_reset_mid();
      int t, nz;
      clr();
      step();
      lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b0; lsb_address_in = 32'h800; lsb_goal_in = 3'd4;
      t = cyc + 1;
      step();
      lsb_request_in = 1'b0;
      step();
      lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b0; lsb_address_in = 32'h900; lsb_goal_in = 3'd1;
      step();
      lsb_request_in = 1'b0;
      n_cmp++;
      if (ram_address_out !== 32'h801) begin
         n_fail++;
         $display("FAIL mid_lw_byte1: addr %h, required 00000801", ram_address_out);
      end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({if_ready_out, if_data_out, lsb_ready_out, lsb_data_out, ram_address_out,
           ram_data_out, ram_rw_signal_out} !== '0) begin
         n_fail++;
         $display("FAIL async_reset_outputs: addr %h rw %b, required all zero", ram_address_out, ram_rw_signal_out);
      end
      step();
      rst = 1'b1;
      t = cyc;
      repeat (12) step();
      nz = 0;
      for (int c = t; c < t + 12; c++) if (atr[c] !== 32'h0) nz++;
      n_cmp++;
      if (lsb_q.size() != 0 || nz != 0) begin
         n_fail++;
         $display("FAIL reset_discard: %0d pulses, %0d busy cycles, required 0/0", lsb_q.size(), nz);
      end
   endtask

   task automatic test_ready_exclusive();
      n_cmp++;
      if (both_cnt != 0) begin
         n_fail++;
         $display("FAIL ready_exclusive: %0d cycles with both ready, required 0", both_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_lsb_load();
      test_lsb_store();
      test_pending_during_if();
      test_io_stall();
      test_rollback();
      test_reset_mid();
      test_ready_exclusive();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
